// File: rtl/score_engine_if.sv
// Signal bundle between the game-state/judge logic and the scoring engine.
interface score_engine_if #(
  parameter int LANES   = 2,
  parameter int SCORE_W = 16,
  parameter int COMBO_W = 8
);
  logic [1:0]         current_state;
  logic [LANES-1:0]   hit;
  logic               miss;
  logic [SCORE_W-1:0] score;
  logic [COMBO_W-1:0] combo;
  logic [COMBO_W-1:0] max_combo;
  logic [4:0]         multiplier;
  logic               score_sat;
  logic               score_upd;

  modport master (
    output current_state, hit, miss,
    input  score, combo, max_combo, multiplier, score_sat, score_upd
  );

  modport slave (
    input  current_state, hit, miss,
    output score, combo, max_combo, multiplier, score_sat, score_upd
  );
endinterface

// File: rtl/score_engine.sv
// Two-stage scoring engine: stage 1 weights lane hits by the combo multiplier
// and tracks combo/max combo, stage 2 accumulates a saturating score.
module score_engine #(
  parameter int LANES      = 2,
  parameter int SCORE_W    = 16,
  parameter int COMBO_W    = 8,
  parameter int BASE_PTS   = 2,
  parameter int COMBO_STEP = 16,
  parameter int MAX_MULT   = 17
) (
  input  logic          clk,
  input  logic          rst,
  score_engine_if.slave bus
);

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_SONG_SELECT = 2'd1;
  localparam logic [1:0] ST_GAME_PLAY   = 2'd2;
  localparam logic [1:0] ST_GAME_OVER   = 2'd3;

  localparam int N_W   = $clog2(LANES + 1);
  localparam int ADD_W = $clog2(LANES * BASE_PTS * MAX_MULT + 1);

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [COMBO_W-1:0] COMBO_MAX = '1;
  localparam logic [COMBO_W:0]   MULT_CAP  = (COMBO_W + 1)'(MAX_MULT);

  logic [SCORE_W-1:0] score_r;
  logic [COMBO_W-1:0] combo_r;
  logic [COMBO_W-1:0] max_r;
  logic [ADD_W-1:0]   add_r;
  logic               sat_r;
  logic               upd_r;

  logic [N_W-1:0]     n;
  logic [COMBO_W:0]   mult_raw;
  logic [4:0]         mult;
  logic [ADD_W-1:0]   add_next;
  logic [COMBO_W:0]   combo_sum;
  logic [COMBO_W-1:0] combo_next;
  logic [COMBO_W-1:0] max_next;
  logic [SCORE_W:0]   score_sum;
  logic               sum_sat;

  always_comb begin
    n = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      n = n + N_W'(bus.hit[i]);
    end
  end

  // Step index is (combo-1)/COMBO_STEP, offset by 2 so combo 1 already doubles.
  always_comb begin
    mult_raw = '0;
    mult     = 5'd1;
    if (combo_r != '0) begin
      mult_raw = (COMBO_W + 1)'((combo_r - 1'b1) / COMBO_STEP) + (COMBO_W + 1)'(2);
      if (mult_raw > MULT_CAP) begin
        mult_raw = MULT_CAP;
      end
      mult = 5'(mult_raw);
    end
  end

  always_comb begin
    add_next   = ADD_W'(n) * ADD_W'(BASE_PTS) * ADD_W'(mult);
    combo_sum  = {1'b0, combo_r} + (COMBO_W + 1)'(n);
    combo_next = (combo_sum > {1'b0, COMBO_MAX}) ? COMBO_MAX : combo_sum[COMBO_W-1:0];
    if (bus.miss) begin
      combo_next = '0;
    end
    max_next  = (combo_next > max_r) ? combo_next : max_r;
    score_sum = {1'b0, score_r} + (SCORE_W + 1)'(add_r);
    sum_sat   = (score_sum >= {1'b0, SCORE_MAX});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      add_r   <= '0;
      combo_r <= '0;
      max_r   <= '0;
    end else begin
      case (bus.current_state)
        ST_SONG_SELECT: begin
          add_r   <= '0;
          combo_r <= '0;
          max_r   <= '0;
        end
        ST_GAME_PLAY: begin
          add_r   <= add_next;
          combo_r <= combo_next;
          max_r   <= max_next;
        end
        ST_IDLE, ST_GAME_OVER: add_r <= '0;
        default: add_r <= '0;
      endcase
    end
  end

  // Stage 2 runs in every non-clearing state so an add issued on the last
  // GAME_PLAY cycle still lands after the state moves on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_r <= '0;
      sat_r   <= 1'b0;
      upd_r   <= 1'b0;
    end else if (bus.current_state == ST_SONG_SELECT) begin
      score_r <= '0;
      sat_r   <= 1'b0;
      upd_r   <= 1'b0;
    end else if (add_r != '0 && score_r != SCORE_MAX) begin
      score_r <= sum_sat ? SCORE_MAX : score_sum[SCORE_W-1:0];
      upd_r   <= 1'b1;
      if (sum_sat) begin
        sat_r <= 1'b1;
      end
    end else begin
      upd_r <= 1'b0;
    end
  end

  assign bus.score      = score_r;
  assign bus.combo      = combo_r;
  assign bus.max_combo  = max_r;
  assign bus.multiplier = mult;
  assign bus.score_sat  = sat_r;
  assign bus.score_upd  = upd_r;

endmodule
